// File: rtl/tx_response_queue_if.sv
// Handshake bundle between the response producer, the byte queue and the TX synchronizer side.
// master: producer/transmitter side; slave: the queue itself.
interface tx_response_queue_if #(
    parameter int BusWidth = 8,
    parameter int PtrWidth = 3
);
    logic [2*BusWidth-1:0] In_Data;
    logic                  In_Valid;
    logic                  In_Word;
    logic                  In_Ready;
    logic                  TX_Busy;
    logic [BusWidth-1:0]   TX_P_Data;
    logic                  TX_D_VLD;
    logic                  Empty;
    logic [PtrWidth:0]     Level;

    modport master (
        output In_Data, In_Valid, In_Word, TX_Busy,
        input  In_Ready, TX_P_Data, TX_D_VLD, Empty, Level
    );

    modport slave (
        input  In_Data, In_Valid, In_Word, TX_Busy,
        output In_Ready, TX_P_Data, TX_D_VLD, Empty, Level
    );
endinterface

// File: rtl/tx_response_queue.sv
// Byte queue feeding the TX synchronizers: buffers byte/word responses and presents one byte at a time
// with a level-held valid and retry-on-timeout. Optional status ports enabled by TX_QUEUE_STATUS_EN.
module tx_response_queue #(
    parameter int BusWidth   = 8,
    parameter int Depth      = 8,
    parameter int PtrWidth   = 3,
    parameter int AckTimeout = 15
) (
    input  logic                     CLK,
    input  logic                     RST,
    tx_response_queue_if.slave       bus
`ifdef TX_QUEUE_STATUS_EN
    ,
    input  logic                     Clr_Status,
    output logic                     Overflow,
    output logic [7:0]               Retry_Cnt
`endif
);
    localparam int TimerWidth = (AckTimeout > 0) ? $clog2(AckTimeout + 1) : 1;
    localparam logic [PtrWidth:0] WordLimit = (PtrWidth+1)'(Depth - 2);
    localparam logic [PtrWidth:0] ByteLimit = (PtrWidth+1)'(Depth - 1);

    typedef enum logic [1:0] {IDLE, HOLD, GAP, DRAIN} state_t;

    state_t                state_reg, state_next;
    logic [BusWidth-1:0]   mem_reg [Depth];
    logic [PtrWidth-1:0]   wr_ptr_reg, wr_ptr_next, wr_ptr_inc;
    logic [PtrWidth-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PtrWidth:0]     level_reg, level_next;
    logic [PtrWidth:0]     push_cnt, pop_cnt;
    logic [TimerWidth-1:0] timer_reg, timer_next;
    logic [BusWidth-1:0]   tx_data_reg, tx_data_next;
    logic                  tx_vld_reg, tx_vld_next;
    logic                  in_ready, push_ok, pop_ok;
    logic [Depth-1:0]      wr_lo_sel, wr_hi_sel;

    // Readiness looks only at the current level; a same-cycle pop is not credited.
    assign in_ready   = bus.In_Word ? (level_reg <= WordLimit) : (level_reg <= ByteLimit);
    assign push_ok    = bus.In_Valid && in_ready;
    assign pop_ok     = (state_reg == IDLE) && (level_reg != '0) && !bus.TX_Busy;
    assign wr_ptr_inc = wr_ptr_reg + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < Depth; gi++) begin : g_wsel
            assign wr_lo_sel[gi] = push_ok && (wr_ptr_reg == PtrWidth'(gi));
            assign wr_hi_sel[gi] = push_ok && bus.In_Word && (wr_ptr_inc == PtrWidth'(gi));
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < Depth; i++) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (wr_lo_sel[i])      mem_reg[i] <= bus.In_Data[BusWidth-1:0];
                else if (wr_hi_sel[i]) mem_reg[i] <= bus.In_Data[2*BusWidth-1:BusWidth];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            timer_reg   <= '0;
            tx_data_reg <= '0;
            tx_vld_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            level_reg   <= level_next;
            timer_reg   <= timer_next;
            tx_data_reg <= tx_data_next;
            tx_vld_reg  <= tx_vld_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rd_ptr_next  = rd_ptr_reg;
        timer_next   = timer_reg;
        tx_data_next = tx_data_reg;
        tx_vld_next  = tx_vld_reg;
        push_cnt     = '0;
        if (push_ok) push_cnt = bus.In_Word ? (PtrWidth+1)'(2) : (PtrWidth+1)'(1);
        pop_cnt      = {{PtrWidth{1'b0}}, pop_ok};
        // Low PtrWidth bits of the push count give the correct wrap even for Depth=2.
        wr_ptr_next  = wr_ptr_reg + push_cnt[PtrWidth-1:0];
        level_next   = level_reg + push_cnt - pop_cnt;

        case (state_reg)
            IDLE: begin
                tx_vld_next = 1'b0;
                if (pop_ok) begin
                    tx_data_next = mem_reg[rd_ptr_reg];
                    rd_ptr_next  = rd_ptr_reg + 1'b1;
                    tx_vld_next  = 1'b1;
                    timer_next   = '0;
                    state_next   = HOLD;
                end
            end
            HOLD: begin
                if (bus.TX_Busy) begin
                    tx_vld_next = 1'b0;
                    state_next  = DRAIN;
                end else if (timer_reg == TimerWidth'(AckTimeout)) begin
                    tx_vld_next = 1'b0;
                    state_next  = GAP;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            GAP: begin
                // Re-present the same byte; the queue is not popped again.
                tx_vld_next = 1'b1;
                timer_next  = '0;
                state_next  = HOLD;
            end
            DRAIN: begin
                if (!bus.TX_Busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.In_Ready  = in_ready;
    assign bus.TX_P_Data = tx_data_reg;
    assign bus.TX_D_VLD  = tx_vld_reg;
    assign bus.Empty     = (level_reg == '0);
    assign bus.Level     = level_reg;

`ifdef TX_QUEUE_STATUS_EN
    logic       overflow_reg;
    logic [7:0] retry_cnt_reg;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            overflow_reg  <= 1'b0;
            retry_cnt_reg <= '0;
        end else begin
            if (bus.In_Valid && !in_ready) overflow_reg <= 1'b1;
            else if (Clr_Status)           overflow_reg <= 1'b0;
            if (Clr_Status)
                retry_cnt_reg <= '0;
            else if (state_reg == HOLD && state_next == GAP && retry_cnt_reg != 8'hFF)
                retry_cnt_reg <= retry_cnt_reg + 1'b1;
        end
    end

    assign Overflow  = overflow_reg;
    assign Retry_Cnt = retry_cnt_reg;
`endif
endmodule

// File: tb/tb_tx_response_queue.sv
// Self-checking bench for tx_response_queue: vector table for basic handshakes plus scoreboard-driven
// sequences for full/near-full, wrap, retry timeout and mid-transfer reset.
module tb_tx_response_queue;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    tx_response_queue_if #(.BusWidth(8), .PtrWidth(3)) bus ();

`ifdef TX_QUEUE_STATUS_EN
    logic       clr_status;
    logic       overflow;
    logic [7:0] retry_cnt;
`endif

    tx_response_queue #(.BusWidth(8), .Depth(8), .PtrWidth(3), .AckTimeout(15)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
`ifdef TX_QUEUE_STATUS_EN
        ,
        .Clr_Status(clr_status),
        .Overflow(overflow),
        .Retry_Cnt(retry_cnt)
`endif
    );

    typedef struct {
        logic        valid;
        logic        word;
        logic [15:0] data;
        logic        busy;
        logic        exp_vld;
        logic [7:0]  exp_data;
        logic [3:0]  exp_level;
        logic        exp_empty;
        logic        exp_ready;
    } vec_t;

    localparam int NV = 14;
    vec_t       vecs [NV];
    logic [7:0] sb [$];
    int         total = 0;
    int         bad = 0;
    int         model_level = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic word, input logic [15:0] data);
        logic exp_ready;
        exp_ready    = word ? (model_level <= 6) : (model_level <= 7);
        bus.In_Valid = 1'b1;
        bus.In_Word  = word;
        bus.In_Data  = data;
        #1;
        check("in_ready", {15'd0, bus.In_Ready}, {15'd0, exp_ready});
        @(negedge CLK);
        if (exp_ready) begin
            sb.push_back(data[7:0]);
            model_level++;
            if (word) begin
                sb.push_back(data[15:8]);
                model_level++;
            end
        end
        bus.In_Valid = 1'b0;
        bus.In_Word  = 1'b0;
        check("push_level", {12'd0, bus.Level}, 16'(model_level));
        $display("push word=%0d data=%h accepted=%0d level=%0d", word, data, exp_ready, bus.Level);
    endtask

    task automatic tx_handshake();
        logic [7:0] exp;
        int n = 0;
        while (!bus.TX_D_VLD && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("tx_vld_rise", {15'd0, bus.TX_D_VLD}, 16'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        model_level--;
        check("tx_data", {8'd0, bus.TX_P_Data}, {8'd0, exp});
        check("pop_level", {12'd0, bus.Level}, 16'(model_level));
        bus.TX_Busy = 1'b1;
        @(negedge CLK);
        check("vld_drop", {15'd0, bus.TX_D_VLD}, 16'd0);
        check("data_held", {8'd0, bus.TX_P_Data}, {8'd0, exp});
        bus.TX_Busy = 1'b0;
        @(negedge CLK);
        $display("tx byte data=%h level=%0d", bus.TX_P_Data, bus.Level);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt;
        int n;
        vecs[0]  = '{1'b1, 1'b0, 16'h005A, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h5A, 4'd0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h5A, 4'd0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h5A, 4'd0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h5A, 4'd0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h5A, 4'd2, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hEF, 4'd1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'hEF, 4'd1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'hEF, 4'd1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hBE, 4'd0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'hBE, 4'd0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'hBE, 4'd0, 1'b1, 1'b1};

        RST          = 1'b0;
        bus.In_Valid = 1'b0;
        bus.In_Word  = 1'b0;
        bus.In_Data  = '0;
        bus.TX_Busy  = 1'b0;
`ifdef TX_QUEUE_STATUS_EN
        clr_status   = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        check("rst_vld", {15'd0, bus.TX_D_VLD}, 16'd0);
        check("rst_data", {8'd0, bus.TX_P_Data}, 16'd0);
        check("rst_level", {12'd0, bus.Level}, 16'd0);
        check("rst_empty", {15'd0, bus.Empty}, 16'd1);
        check("rst_ready", {15'd0, bus.In_Ready}, 16'd1);
        RST = 1'b1;

        // Single byte and single word handshakes, cycle by cycle.
        for (int i = 0; i < NV; i++) begin
            bus.In_Valid = vecs[i].valid;
            bus.In_Word  = vecs[i].word;
            bus.In_Data  = vecs[i].data;
            bus.TX_Busy  = vecs[i].busy;
            @(negedge CLK);
            check("vec_vld", {15'd0, bus.TX_D_VLD}, {15'd0, vecs[i].exp_vld});
            check("vec_data", {8'd0, bus.TX_P_Data}, {8'd0, vecs[i].exp_data});
            check("vec_level", {12'd0, bus.Level}, {12'd0, vecs[i].exp_level});
            check("vec_empty", {15'd0, bus.Empty}, {15'd0, vecs[i].exp_empty});
            check("vec_ready", {15'd0, bus.In_Ready}, {15'd0, vecs[i].exp_ready});
            $display("vec %0d vld=%0d data=%h level=%0d", i, bus.TX_D_VLD, bus.TX_P_Data, bus.Level);
        end
        bus.In_Valid = 1'b0;
        bus.In_Word  = 1'b0;
        model_level  = 0;

        // Fill with four words while the transmitter is busy, then drop pushes when full.
        bus.TX_Busy = 1'b1;
        push(1'b1, 16'hA1B2);
        push(1'b1, 16'hC3D4);
        push(1'b1, 16'hE5F6);
        push(1'b1, 16'h0718);
        push(1'b1, 16'hDEAD);
        push(1'b0, 16'h0099);
        check("full_empty", {15'd0, bus.Empty}, 16'd0);
`ifdef TX_QUEUE_STATUS_EN
        check("overflow_set", {15'd0, overflow}, 16'd1);
        clr_status = 1'b1;
        @(negedge CLK);
        clr_status = 1'b0;
        check("overflow_clr", {15'd0, overflow}, 16'd0);
`endif
        bus.TX_Busy = 1'b0;
        for (int i = 0; i < 8; i++) tx_handshake();
        check("drain_empty", {15'd0, bus.Empty}, 16'd1);

        // Level 7: word rejected, byte accepted.
        bus.TX_Busy = 1'b1;
        for (int i = 0; i < 7; i++) push(1'b0, 16'(8'h40 + i));
        push(1'b1, 16'h9988);
        push(1'b0, 16'h0055);
        bus.TX_Busy = 1'b0;
        for (int i = 0; i < 8; i++) tx_handshake();

        // No acknowledge: 16 cycles valid, one cycle gap, same byte again.
        push(1'b0, 16'h003C);
        n = 0;
        while (!bus.TX_D_VLD && n < 10) begin
            @(negedge CLK);
            n++;
        end
        hi_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.TX_D_VLD && bus.TX_P_Data == 8'h3C) hi_cnt++;
            @(negedge CLK);
        end
        check("retry_high_cycles", 16'(hi_cnt), 16'd16);
        check("retry_gap_vld", {15'd0, bus.TX_D_VLD}, 16'd0);
        check("retry_gap_data", {8'd0, bus.TX_P_Data}, 16'h003C);
        @(negedge CLK);
        check("retry_again_vld", {15'd0, bus.TX_D_VLD}, 16'd1);
        check("retry_again_data", {8'd0, bus.TX_P_Data}, 16'h003C);
`ifdef TX_QUEUE_STATUS_EN
        check("retry_cnt", {8'd0, retry_cnt}, 16'd1);
`endif
        tx_handshake();

        // Reset while a byte is held and three remain queued.
        bus.TX_Busy = 1'b1;
        push(1'b0, 16'h0011);
        push(1'b0, 16'h0022);
        push(1'b0, 16'h0033);
        push(1'b0, 16'h0044);
        bus.TX_Busy = 1'b0;
        @(negedge CLK);
        check("hold_vld", {15'd0, bus.TX_D_VLD}, 16'd1);
        check("hold_level", {12'd0, bus.Level}, 16'd3);
        RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_vld", {15'd0, bus.TX_D_VLD}, 16'd0);
        check("mid_rst_level", {12'd0, bus.Level}, 16'd0);
        check("mid_rst_empty", {15'd0, bus.Empty}, 16'd1);
        check("mid_rst_data", {8'd0, bus.TX_P_Data}, 16'd0);
        RST = 1'b1;
        sb.delete();
        model_level = 0;
        @(negedge CLK);
        check("post_rst_idle", {15'd0, bus.TX_D_VLD}, 16'd0);
        push(1'b0, 16'h0077);
        tx_handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
